// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with a 2-entry skid buffer.
//
// Splits the incoming instruction into its fields, builds the sign-extended
// XLEN immediate, classifies the format, flags illegal encodings and drives
// the register enables. Decode is combinational on in_instr. The decoded
// bundle is stored in OUT, or in SKID when OUT is stalled, so the stage can
// accept one instruction per cycle even while the consumer applies
// backpressure.
//
// Optional feature: define DECODE_MEXT_EN to accept OP encodings with
// funct7=0000001 (M extension) as legal R-type and raise is_muldiv.
//
// Ports:
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   flush                 discard every buffered instruction
//   in_valid/in_ready     fetch handshake (in_ready is registered)
//   in_instr, in_pc       instruction word and its address
//   out_valid/out_ready   downstream handshake
//   out_pc, rs1, rs2, rd, opcode, funct3, funct7   raw fields of OUT
//   imm, fmt              immediate and format (0=R 1=I 2=S 3=B 4=U 5=J 7=illegal)
//   rs1_en, rs2_en, rd_we register read/write enables
//   illegal, is_muldiv    classification flags
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            rs1_en,
    output logic            rs2_en,
    output logic            rd_we,
    output logic            illegal,
    output logic            is_muldiv
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd7;

    // The raw instruction is kept so the field outputs are plain slices.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic            illegal;
        logic            is_muldiv;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t  state, next_state;
    bundle_t dec, out_q, skid_q;
    logic    load_out, load_skid, skid_to_out;
    logic    in_fire, out_fire;

    logic [6:0]  op_c, f7_c;
    logic [2:0]  f3_c, fmt_c;
    logic        md_c;
    logic [31:0] imm32;

    // ---------------- combinational decode ----------------
    always_comb begin
        op_c  = in_instr[6:0];
        f3_c  = in_instr[14:12];
        f7_c  = in_instr[31:25];
        fmt_c = FMT_BAD;
        md_c  = 1'b0;
        imm32 = '0;

        // Every legal opcode ends in 2'b11, so the compressed-space check
        // falls out of matching the full 7-bit opcode.
        case (op_c)
            7'b0110111, 7'b0010111: fmt_c = FMT_U;
            7'b1101111:             fmt_c = FMT_J;
            7'b1100111:             if (f3_c == 3'b000) fmt_c = FMT_I;
            7'b1100011:             if (f3_c != 3'b010 && f3_c != 3'b011) fmt_c = FMT_B;
            7'b0000011:             if (f3_c != 3'b011 && f3_c != 3'b110 && f3_c != 3'b111) fmt_c = FMT_I;
            7'b0100011:             if (f3_c <= 3'b010) fmt_c = FMT_S;
            7'b0010011: begin
                // Shift-immediates reuse funct7 as an opcode extension.
                if (f3_c == 3'b001) begin
                    if (f7_c == 7'b0000000) fmt_c = FMT_I;
                end else if (f3_c == 3'b101) begin
                    if (f7_c == 7'b0000000 || f7_c == 7'b0100000) fmt_c = FMT_I;
                end else begin
                    fmt_c = FMT_I;
                end
            end
            7'b0110011: begin
                if (f7_c == 7'b0000000) fmt_c = FMT_R;
                else if (f7_c == 7'b0100000 && (f3_c == 3'b000 || f3_c == 3'b101)) fmt_c = FMT_R;
`ifdef DECODE_MEXT_EN
                else if (f7_c == 7'b0000001) begin
                    fmt_c = FMT_R;
                    md_c  = 1'b1;
                end
`endif
            end
            7'b0001111, 7'b1110011: fmt_c = FMT_I;
            default:                fmt_c = FMT_BAD;
        endcase

        case (fmt_c)
            FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        dec           = '0;
        dec.pc        = in_pc;
        dec.instr     = in_instr;
        dec.fmt       = fmt_c;
        // Sign-extending cast widens the 32-bit immediate to XLEN.
        dec.imm       = XLEN'($signed(imm32));
        dec.illegal   = (fmt_c == FMT_BAD);
        dec.rs1_en    = (fmt_c == FMT_R) || (fmt_c == FMT_I) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
        dec.rs2_en    = (fmt_c == FMT_R) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
        dec.rd_we     = ((fmt_c == FMT_R) || (fmt_c == FMT_I) || (fmt_c == FMT_U) || (fmt_c == FMT_J))
                        && (in_instr[11:7] != 5'd0);
        dec.is_muldiv = md_c;
    end

    // ---------------- handshake FSM ----------------
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        next_state  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    next_state = ONE;
                    load_out   = 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_out = 1'b1;
                    end else if (in_fire) begin
                        next_state = TWO;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        next_state = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    next_state  = ONE;
                    skid_to_out = 1'b1;
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else begin
            state    <= next_state;
            // Registered ready: low exactly while both entries are occupied.
            in_ready <= (next_state != TWO);
            if (load_out)         out_q <= dec;
            else if (skid_to_out) out_q <= skid_q;
            if (load_skid)        skid_q <= dec;
        end
    end

    // ---------------- bundle outputs ----------------
    assign out_pc    = out_q.pc;
    assign rs1       = out_q.instr[19:15];
    assign rs2       = out_q.instr[24:20];
    assign rd        = out_q.instr[11:7];
    assign opcode    = out_q.instr[6:0];
    assign funct3    = out_q.instr[14:12];
    assign funct7    = out_q.instr[31:25];
    assign imm       = out_q.imm;
    assign fmt       = out_q.fmt;
    assign rs1_en    = out_q.rs1_en;
    assign rs2_en    = out_q.rs2_en;
    assign rd_we     = out_q.rd_we;
    assign illegal   = out_q.illegal;
    assign is_muldiv = out_q.is_muldiv;

endmodule
